// File: rtl/mdu_unit_if.sv
// Request/result bundle between the E stage and the multiply/divide unit.
// The E stage is the master and drives the request; the unit reports Busy and HI/LO.
interface mdu_unit_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, Req, input  Busy, HI, LO);
  modport slave  (input  Start, MDUOp, A, B, Req, output Busy, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit. It holds HI/LO, runs mult/div for a fixed latency
// with Busy high, and commits the precomputed result when the countdown expires.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_commit_q, pend_commit_d;

  logic        accept;
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, sq_mag, sr_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign accept = bus.Start && !bus.Req && (state_q == S_IDLE);

  // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0.
  always_comb begin
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    mag_a  = bus.A[31] ? -bus.A : bus.A;
    mag_b  = bus.B[31] ? -bus.B : bus.B;
    sq_mag = '0;
    sr_mag = '0;
    quo_u  = '0;
    rem_u  = '0;
    if (bus.B != '0) begin
      sq_mag = mag_a / mag_b;
      sr_mag = mag_a % mag_b;
      quo_u  = bus.A / bus.B;
      rem_u  = bus.A % bus.B;
    end
    quo_s = (bus.A[31] ^ bus.B[31]) ? -sq_mag : sq_mag;
    rem_s = bus.A[31] ? -sr_mag : sr_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      pend_hi_q     <= '0;
      pend_lo_q     <= '0;
      pend_commit_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      pend_commit_q <= pend_commit_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves it unassigned
    // (which would infer a latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    pend_hi_d     = pend_hi_q;
    pend_lo_d     = pend_lo_q;
    pend_commit_d = pend_commit_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.MDUOp)
            OP_MULT, OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = (bus.MDUOp == OP_MULT) ? prod_s : prod_u;
              pend_commit_d          = 1'b1;
              cnt_d                  = MULT_N;
              state_d                = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d     = (bus.MDUOp == OP_DIV) ? rem_s : rem_u;
              pend_lo_d     = (bus.MDUOp == OP_DIV) ? quo_s : quo_u;
              pend_commit_d = (bus.B != '0);
              cnt_d         = DIV_N;
              state_d       = S_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (pend_commit_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Busy = (state_q == S_RUN);
    bus.HI   = hi_q;
    bus.LO   = lo_q;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the E stage. It produces the `Busy` signal that the D-stage stall logic consumes. The unit accepts mult/multu/div/divu/mthi/mtlo requests from E and holds the HI/LO architectural registers. A multi-cycle operation keeps `Busy` high for a fixed latency and commits HI/LO at the end. The stall logic combines `Busy` with the E-stage md decode, so D-stage mf/md/mt instructions are held until the unit is idle.

Parameters:
MULT_CYCLES, 5, cycles `Busy` stays high for mult/multu (legal range 1..15).
DIV_CYCLES, 10, cycles `Busy` stays high for div/divu (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
Start  input  1  E-stage request valid; one-cycle pulse per instruction.
MDUOp  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved (no-op).
A  input  32  rs operand (forwarded value).
B  input  32  rt operand (forwarded value).
Req  input  1  exception/interrupt flush of the E-stage instruction.
Busy  output  1  multi-cycle operation in progress.
HI  output  32  HI register.
LO  output  32  LO register.

Behaviour:
- Reset (reset==0, asynchronous):
  - Busy=0, HI=0, LO=0.
  - State=IDLE, counter=0, pending results cleared.
  - Reset asserted mid-operation aborts the operation; no HI/LO commit afterwards.
- Request acceptance: Start && !Req && state==IDLE. Requests are sampled on the rising edge.
- State machine, IDLE -> RUN:
  - Trigger: accepted op 0..3.
  - On that edge: compute the 64-bit result from A/B into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy<=1.
- State machine, RUN:
  - Each edge decrements the counter.
  - On the edge where counter==1: HI<=pending_hi, LO<=pending_lo, Busy<=0, state<=IDLE.
- Latency: Busy is high for exactly N consecutive cycles, starting the cycle after the Start edge. The new HI/LO values are visible in the same cycle Busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 -> {HI,LO}.
  - multu: unsigned 32x32 -> {HI,LO}.
  - div: LO=signed quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - Divide by zero (B==0, op 2/3): the op still runs the full DIV_CYCLES with Busy high, but HI/LO are left unchanged at completion.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo (ops 4/5):
  - Accepted in IDLE only; on the accept edge HI<=A (mthi) or LO<=A (mtlo).
  - Busy stays 0; single-cycle.
- Reserved ops 6/7: no state change.
- Start while in RUN: ignored (no operand capture, no HI/LO write). The stall logic guarantees this does not occur legitimately.
- Req: when Req=1 on the Start edge, the request is dropped entirely. An operation already in RUN is not cancelled by Req and completes normally.
- Operand inputs A/B are don't-care except on the accept edge; results are held internally.
- HI/LO change only at reset, at RUN completion, or on an accepted mthi/mtlo.

Test Plan:
- Signed mult: Start, op=0, A=0xFFFFFFFD (-3), B=4.
  - Busy=1 for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFF4, with HI/LO unchanged during Busy.
- Unsigned mult: op=1, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: op=2, A=0xFFFFFFF9 (-7), B=2.
  - Busy=1 for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned div by zero: preload HI=0x11, LO=0x22 via mthi/mtlo (Busy remains 0 both cycles).
  - Then op=3, A=7, B=0 -> Busy 10 cycles; HI=0x11, LO=0x22 afterwards.
- Start during RUN and Req:
  - Start op=5 A=0xAB issued during RUN of a mult -> LO ends with the mult result, not 0xAB.
  - Start op=0 with Req=1 in IDLE -> Busy stays 0, HI/LO unchanged.
- Reset mid-operation: drive reset=0 asynchronously in the 3rd busy cycle of a div.
  - Busy, HI, LO drop to 0 immediately, without waiting for a clock edge.
  - After release, no commit occurs and a new mult completes normally.
